ac_scan_sequencer: RTL
======================

Name: ac_scan_sequencer

Overview:
- Sequences one slice's AC coefficients out of the quantized-coefficient buffer in ProRes interleaved scan order: for scan position 1..63, then for block 0..N-1.
- Feeds the AC run/level entropy encoders one coefficient per cycle, with a valid strobe.
- Flushes the encoder pipeline before signalling completion to the slice controller.
- Sits between the quantizer output RAM and the VLC run/level coders.

Parameters:
- MAX_BLOCKS, 32, maximum blocks per slice; num_blocks above this clamps to MAX_BLOCKS.
- ADDR_W, 11, coefficient RAM address width; must satisfy 2^ADDR_W >= MAX_BLOCKS*64.
- DRAIN_CYCLES, 6, cycles waited after the last coeff_valid before done; covers downstream encoder latency.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request to begin a slice; sampled only in IDLE.
- abort  in  1  cancel the current slice; highest priority after reset.
- num_blocks  in  6  blocks in the slice; latched on accepted start.
- rd_en  out  1  coefficient RAM read enable.
- rd_addr  out  ADDR_W  RAM address = block*64 + scan_pos.
- rd_data  in  32  signed coefficient, valid the cycle after rd_en.
- enc_clear  out  1  one-cycle pulse telling downstream coders to reinitialise run/previousRun state.
- coeff_out  out  32  registered coefficient to the run/level encoders.
- coeff_valid  out  1  coeff_out valid; drives encoder input_enable.
- last_coeff  out  1  high with the final coefficient of the slice.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0: rd_en, rd_addr, enc_clear, coeff_out, coeff_valid, last_coeff, busy, done.
  - Internal block/position counters 0.
  - Reset mid-slice discards all progress.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 latches N = min(num_blocks, MAX_BLOCKS).
  - N=0: go to DONE.
  - Otherwise go to READ with block=0, pos=1.
  - enc_clear pulses in the cycle following the accepted start, for both cases.
- READ:
  - One read per cycle: rd_en=1, rd_addr = block*64 + pos.
  - block increments every cycle. At block=N-1 it wraps to 0 and pos increments.
  - After the read with pos=63, block=N-1, go to DRAIN.
  - No gaps; exactly N*63 reads.
- Data path, fixed 2-cycle latency:
  - rd_en at cycle k gives rd_data at k+1.
  - coeff_out/coeff_valid are registered at k+2.
  - last_coeff is pipelined identically and marks the read with pos=63, block=N-1.
  - coeff_out holds its value when coeff_valid=0.
- DRAIN: counts so that done asserts exactly DRAIN_CYCLES cycles after the cycle carrying last_coeff.
- DONE:
  - done=1 for one cycle, then IDLE.
  - busy stays high through the DONE cycle.
- Timing for start accepted at cycle t, N>0:
  - enc_clear at t+1.
  - First read at t+1; first coeff_valid at t+3.
  - last_coeff at t+N*63+2.
  - done at t+N*63+2+DRAIN_CYCLES.
- Timing for N=0: enc_clear and done both at t+1; no reads, no coeff_valid.
- start while busy: ignored, no queuing.
- start in the same cycle done is high: ignored, because state is not yet IDLE.
- abort=1 in any non-IDLE state:
  - Next cycle: state IDLE; rd_en, coeff_valid, last_coeff, busy all 0.
  - Any in-flight read is dropped; no done pulse.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: start wins.
- Arithmetic:
  - Counters are sized for MAX_BLOCKS.
  - The address is formed by concatenating block and a 6-bit pos; no multiplier.

Optional Feature:
- Macro: AC_SCAN_NZ_STATS_EN.
- With the macro defined:
  - Extra output port nz_count, 12 bits, counts coeff_valid cycles where coeff_out != 0.
  - Cleared to 0 on reset and on accepted start.
  - Stable from done until the next accepted start.
  - Cleared on abort.
- Without it: no nz_count port and no counter logic; all other behaviour identical.

Test Plan:
- Reset held 3 cycles, then released with no start -> all outputs 0, busy=0, for 20 cycles.
- N=1, RAM[a]=a, start at cycle t -> rd_addr 1..63 at t+1..t+63; coeff_out 1..63 at t+3..t+65; last_coeff at t+65 only; done at t+71; enc_clear at t+1.
- N=4, RAM[a]=a -> coeff_out order 1,65,129,193,2,66,... ending 255 with last_coeff; 252 valid cycles; done at t+260.
- num_blocks=0 -> enc_clear and done at t+1; zero rd_en and coeff_valid cycles. num_blocks=40 -> clamps to 32 (2016 coefficients).
- abort asserted mid-READ at read #10; start pulsed during busy -> busy=0 next cycle, no done, start ignored. A fresh start then runs cleanly from pos=1, block=0.
- With AC_SCAN_NZ_STATS_EN, N=2, RAM nonzero only at addresses 5, 70, 127 -> nz_count=3 at done; cleared to 0 by the next start.

Source files
------------

// File: rtl/ac_scan_sequencer.sv
// AC coefficient scan sequencer: reads a slice's AC coefficients in interleaved
// scan order (pos 1..63 outer, block 0..N-1 inner). Optional macro: AC_SCAN_NZ_STATS_EN.
module ac_scan_sequencer #(
    parameter int MAX_BLOCKS   = 32,
    parameter int ADDR_W       = 11,
    parameter int DRAIN_CYCLES = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [5:0]        num_blocks,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              enc_clear,
    output logic [31:0]       coeff_out,
    output logic              coeff_valid,
    output logic              last_coeff,
    output logic              busy,
    output logic              done
`ifdef AC_SCAN_NZ_STATS_EN
    ,
    output logic [11:0]       nz_count
`endif
);

    localparam int NB_W  = $clog2(MAX_BLOCKS + 1);
    localparam int BLK_W = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
    localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic [NB_W-1:0]   nblk_r;
    logic [NB_W-1:0]   nblk_nx_s;
    logic [NB_W-1:0]   block_r;
    logic [NB_W-1:0]   block_nx_s;
    logic [5:0]        pos_r;
    logic [5:0]        pos_nx_s;
    logic [CNT_W-1:0]  drain_cnt_r;
    logic [CNT_W-1:0]  drain_cnt_nx_s;
    logic              rd_en_nx_s;
    logic              enc_clear_nx_s;
    logic              done_nx_s;
    logic [NB_W-1:0]   clamp_s;
    logic [NB_W-1:0]   last_blk_s;
    logic              read_last_s;
    logic              abort_act_s;
    logic [ADDR_W-1:0] rd_addr_nx_s;
    logic              rd_vld_d1_r;
    logic              last_d1_r;

    assign clamp_s      = ({26'd0, num_blocks} > 32'(MAX_BLOCKS)) ? NB_W'(MAX_BLOCKS) : NB_W'(num_blocks);
    assign last_blk_s   = nblk_r - NB_W'(1);
    assign read_last_s  = (pos_r == 6'd63) && (block_r == last_blk_s);
    assign abort_act_s  = abort && (state_r != ST_IDLE);
    assign rd_addr_nx_s = ADDR_W'({block_nx_s[BLK_W-1:0], pos_nx_s});

    // Next-state and counter advance; abort overrides everything but reset.
    always_comb begin
        state_nx_s     = state_r;
        nblk_nx_s      = nblk_r;
        block_nx_s     = block_r;
        pos_nx_s       = pos_r;
        drain_cnt_nx_s = drain_cnt_r;
        rd_en_nx_s     = 1'b0;
        enc_clear_nx_s = 1'b0;
        done_nx_s      = 1'b0;
        if (abort_act_s) begin
            state_nx_s     = ST_IDLE;
            block_nx_s     = {NB_W{1'b0}};
            pos_nx_s       = 6'd0;
            drain_cnt_nx_s = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        nblk_nx_s      = clamp_s;
                        block_nx_s     = {NB_W{1'b0}};
                        pos_nx_s       = 6'd1;
                        enc_clear_nx_s = 1'b1;
                        if (clamp_s == {NB_W{1'b0}}) begin
                            state_nx_s = ST_DONE;
                            done_nx_s  = 1'b1;
                        end else begin
                            state_nx_s = ST_READ;
                            rd_en_nx_s = 1'b1;
                        end
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (read_last_s) begin
                        state_nx_s     = ST_DRAIN;
                        drain_cnt_nx_s = {CNT_W{1'b0}};
                    end else if (block_r == last_blk_s) begin
                        rd_en_nx_s = 1'b1;
                        block_nx_s = {NB_W{1'b0}};
                        pos_nx_s   = pos_r + 6'd1;
                    end else begin
                        rd_en_nx_s = 1'b1;
                        block_nx_s = block_r + NB_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // DRAIN is entered one cycle before last_coeff appears, hence the inclusive count.
                    if (drain_cnt_r == CNT_W'(DRAIN_CYCLES)) begin
                        state_nx_s = ST_DONE;
                        done_nx_s  = 1'b1;
                    end else begin
                        drain_cnt_nx_s = drain_cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_nx_s = ST_IDLE;
                    block_nx_s = {NB_W{1'b0}};
                    pos_nx_s   = 6'd0;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // Control state and registered read/handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            nblk_r      <= {NB_W{1'b0}};
            block_r     <= {NB_W{1'b0}};
            pos_r       <= 6'd0;
            drain_cnt_r <= {CNT_W{1'b0}};
            rd_en       <= 1'b0;
            rd_addr     <= {ADDR_W{1'b0}};
            enc_clear   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            nblk_r      <= nblk_nx_s;
            block_r     <= block_nx_s;
            pos_r       <= pos_nx_s;
            drain_cnt_r <= drain_cnt_nx_s;
            rd_en       <= rd_en_nx_s;
            rd_addr     <= rd_en_nx_s ? rd_addr_nx_s : {ADDR_W{1'b0}};
            enc_clear   <= enc_clear_nx_s;
            busy        <= (state_nx_s != ST_IDLE);
            done        <= done_nx_s;
        end
    end

    // Two-stage data path aligned with the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_d1_r <= 1'b0;
            last_d1_r   <= 1'b0;
            coeff_valid <= 1'b0;
            last_coeff  <= 1'b0;
            coeff_out   <= 32'd0;
        end else if (abort_act_s) begin
            rd_vld_d1_r <= 1'b0;
            last_d1_r   <= 1'b0;
            coeff_valid <= 1'b0;
            last_coeff  <= 1'b0;
        end else begin
            rd_vld_d1_r <= rd_en;
            last_d1_r   <= rd_en && read_last_s;
            coeff_valid <= rd_vld_d1_r;
            last_coeff  <= last_d1_r;
            if (rd_vld_d1_r) begin
                coeff_out <= rd_data;
            end else begin
                coeff_out <= coeff_out;
            end
        end
    end

`ifdef AC_SCAN_NZ_STATS_EN
    // Nonzero coefficient statistic, held from done until the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            nz_count <= 12'd0;
        end else if (abort_act_s || (state_r == ST_IDLE && start)) begin
            nz_count <= 12'd0;
        end else if (coeff_valid && (coeff_out != 32'd0)) begin
            nz_count <= nz_count + 12'd1;
        end else begin
            nz_count <= nz_count;
        end
    end
`endif

endmodule
